hex_display_mm: RTL and testbench

//  Avalon-MM slave driving NUM_DIGITS seven-segment digits from a double-buffered value register.
//  CPU writes the shadow value, then commits it atomically, so displayed digits never tear.

---
 rtl/hex_display_mm.sv | 141 ++++++++++++++
 tb/tb_hex_display_mm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_mm.sv
// Avalon-MM seven-segment driver with double-buffered value, per-digit enable and leading-zero blanking.
// Optional blink logic is built only when HEX_BLINK_EN is defined.
module hex_display_mm #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      avs_waitrequest,
  output logic [7*NUM_DIGITS-1:0]   hex_out
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [7*NUM_DIGITS-1:0] HEX_OFF = (ACTIVE_LOW != 0) ? {(7*NUM_DIGITS){1'b1}} : '0;

  // Handshake: waitrequest is always low, so an access is accepted in the cycle it is
  // presented; a read returns readdata with readdatavalid high on exactly the next cycle.
  assign avs_waitrequest = 1'b0;

  logic [W-1:0]          shadow;
  logic [W-1:0]          active;
  logic [NUM_DIGITS-1:0] enable;
  logic                  lzb;
  logic [15:0]           commit_cnt;
  logic [NUM_DIGITS-1:0] blink_off;
  logic [NUM_DIGITS-1:0] blink_rd;
  logic [31:0]           rd_next;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [NUM_DIGITS:0]   upper_zero;
  logic                  unused_ok;

  assign unused_ok = ^avs_writedata;

  wire wr_blink = avs_write && (avs_address == 3'd4);

`ifdef HEX_BLINK_EN
  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0]         prescaler;
  logic                  phase_off;
  logic [NUM_DIGITS-1:0] blink_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      phase_off  <= 1'b0;
      blink_mask <= '0;
    end else if (wr_blink) begin
      // Rewriting the mask restarts the blink so the new pattern begins in the ON phase.
      prescaler  <= '0;
      phase_off  <= 1'b0;
      blink_mask <= avs_writedata[NUM_DIGITS-1:0];
    end else if (prescaler == PW'(BLINK_DIV - 1)) begin
      prescaler <= '0;
      phase_off <= ~phase_off;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  assign blink_off = phase_off ? blink_mask : '0;
  assign blink_rd  = blink_mask;
`else
  assign blink_off = '0;
  assign blink_rd  = '0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    rd_next = '0;
    case (avs_address)
      3'd0: rd_next[W-1:0] = shadow;
      3'd1: rd_next[W-1:0] = active;
      3'd2: rd_next[NUM_DIGITS-1:0] = enable;
      3'd3: rd_next[15:0] = commit_cnt;
      3'd4: rd_next[NUM_DIGITS-1:0] = blink_rd;
      3'd5: rd_next[0] = lzb;
      default: rd_next = '0;
    endcase
  end

  // upper_zero[d] is set when digits d..N-1 of the active value are all zero.
  always_comb begin
    logic [6:0] seg;
    hex_next = '0;
    upper_zero = '0;
    upper_zero[NUM_DIGITS] = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      upper_zero[d] = upper_zero[d+1] && (active[4*d +: 4] == 4'h0);
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      seg = glyph(active[4*d +: 4]);
      if (!enable[d] || (lzb && (d != 0) && upper_zero[d]) || blink_off[d]) seg = 7'h00;
      hex_next[7*d +: 7] = (ACTIVE_LOW != 0) ? ~seg : seg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow            <= '0;
      active            <= '0;
      enable            <= '0;
      lzb               <= 1'b0;
      commit_cnt        <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      hex_out           <= HEX_OFF;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_next;
      hex_out <= hex_next;
      if (avs_write) begin
        case (avs_address)
          3'd0: shadow <= avs_writedata[W-1:0];
          3'd2: enable <= avs_writedata[NUM_DIGITS-1:0];
          3'd3: begin
            active     <= shadow;
            commit_cnt <= commit_cnt + 16'd1;
          end
          3'd5: lzb <= avs_writedata[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_display_mm.sv
// Bench for hex_display_mm: register-level behavioural model checked every cycle, plus literal checks.
module tb_hex_display_mm;

  localparam int N   = 6;
  localparam int W   = 4 * N;
  localparam int DIV = 4;
  localparam int HW  = 7 * N;
`ifdef HEX_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          avs_waitrequest;
  logic [HW-1:0] hex_out;

  int n_cmp = 0;
  int n_bad = 0;

  hex_display_mm #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest), .hex_out(hex_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [W-1:0]  m_shadow = '0, m_active = '0;
  logic [N-1:0]  m_en = '0, m_blink = '0;
  logic          m_lzb = 1'b0;
  int            m_cnt = 0;
  int            m_k = 0;  // clock edges since reset or the last BLINK write
  logic [HW-1:0] exp_hex = '1;
  logic          exp_rv = 1'b0;
  logic [31:0]   exp_q[$];

  function automatic logic [HW-1:0] model_hex();
    logic [HW-1:0] r;
    logic [6:0] seg;
    bit blank;
    r = '0;
    for (int d = 0; d < N; d++) begin
      blank = !m_en[d] || (m_lzb && d > 0 && (m_active >> (4 * d)) == 0);
      if (BLINK_EN && m_blink[d] && ((m_k / DIV) % 2 == 1)) blank = 1;
      seg = blank ? 7'h00 : glyph_tab[(m_active >> (4 * d)) & 4'hF];
      r[7*d +: 7] = ~seg;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_shadow);
      3'd1: return 32'(m_active);
      3'd2: return 32'(m_en);
      3'd3: return 32'(m_cnt % 65536);
      3'd4: return BLINK_EN ? 32'(m_blink) : 32'd0;
      3'd5: return 32'(m_lzb);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_shadow = '0; m_active = '0; m_en = '0; m_blink = '0; m_lzb = 0;
      m_cnt = 0; m_k = 0; exp_hex = '1; exp_rv = 0;
      exp_q.delete();
    end else begin
      exp_hex = model_hex();
      exp_rv  = avs_read;
      if (avs_read) exp_q.push_back(model_read(avs_address));
      m_k = m_k + 1;
      if (avs_write) begin
        case (avs_address)
          3'd0: m_shadow = avs_writedata[W-1:0];
          3'd2: m_en = avs_writedata[N-1:0];
          3'd3: begin m_active = m_shadow; m_cnt = m_cnt + 1; end
          3'd4: if (BLINK_EN) begin m_blink = avs_writedata[N-1:0]; m_k = 0; end
          3'd5: m_lzb = avs_writedata[0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
      chk("rst_rv", 64'(avs_readdatavalid), 64'd0);
      chk("rst_rd", 64'(avs_readdata), 64'd0);
    end else begin
      chk("hex", 64'(hex_out), 64'(exp_hex));
      chk("rv", 64'(avs_readdatavalid), 64'(exp_rv));
      chk("waitreq", 64'(avs_waitrequest), 64'd0);
      if (avs_readdatavalid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 64'(avs_readdatavalid), 64'd0);
        else chk("rdata", 64'(avs_readdata), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d);
    avs_read = r; avs_write = w; avs_address = a; avs_writedata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 3'd0, 32'd0);
  endtask

  logic [HW-1:0] lit;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      cyc(1, 0, 3'(a), 32'd0);
      #1 chk("reset_read_data", 64'(avs_readdata), 64'd0);
      chk("reset_read_valid", 64'(avs_readdatavalid), 64'd1);
    end
    idle(1);
    #1 chk("valid_drops", 64'(avs_readdatavalid), 64'd0);
    chk("reset_hex_all_off", 64'(hex_out), 64'({HW{1'b1}}));

    cyc(0, 1, 3'd0, 32'h12AF);
    cyc(0, 1, 3'd2, 32'h3F);
    cyc(1, 0, 3'd1, 32'd0);
    #1 chk("active_before_commit", 64'(avs_readdata), 64'd0);
    cyc(0, 1, 3'd3, 32'hDEAD);
    idle(1);
    lit = {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E};
    #1 chk("commit_glyphs", 64'(hex_out), 64'(lit));
    cyc(1, 0, 3'd3, 32'd0);
    #1 chk("commit_cnt_1", 64'(avs_readdata), 64'd1);

    cyc(0, 1, 3'd0, 32'h000120);
    cyc(0, 1, 3'd3, 32'd0);
    cyc(0, 1, 3'd5, 32'd1);
    idle(1);
    lit = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40};
    #1 chk("lzb_120", 64'(hex_out), 64'(lit));
    cyc(0, 1, 3'd0, 32'd0);
    cyc(0, 1, 3'd3, 32'd0);
    idle(1);
    lit = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    #1 chk("lzb_zero", 64'(hex_out), 64'(lit));

    cyc(1, 1, 3'd0, 32'hFFABCDEF);
    #1 chk("rw_same_cycle_old", 64'(avs_readdata), 64'd0);
    cyc(1, 0, 3'd0, 32'd0);
    #1 chk("shadow_masked", 64'(avs_readdata), 64'hABCDEF);

    cyc(0, 1, 3'd5, 32'd0);
    cyc(0, 1, 3'd4, 32'h01);
    idle(5);
    #1 chk("blink_digit0_off", 64'(hex_out[6:0]), BLINK_EN ? 64'h7F : 64'h40);
    cyc(1, 0, 3'd4, 32'd0);
    #1 chk("blink_read", 64'(avs_readdata), BLINK_EN ? 64'd1 : 64'd0);
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      bit r, w;
      logic [2:0] a;
      logic [31:0] d;
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      a = 3'($urandom_range(0, 7));
      if (a == 3'd4 && $urandom_range(0, 7) != 0) w = 0;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = d & 32'h0000_0F0F;
      cyc(r, w, a, d);
    end
    idle(2);

    cyc(0, 1, 3'd0, 32'h654321);
    cyc(0, 1, 3'd3, 32'd0);
    cyc(0, 1, 3'd4, 32'h3F);
    idle(6);
    avs_read = 1'b1; avs_address = 3'd0;
    #2 rst = 1'b1;
    #1 chk("async_rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
    chk("async_rst_rv", 64'(avs_readdatavalid), 64'd0);
    chk("async_rst_rd", 64'(avs_readdata), 64'd0);
    avs_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (65535) cyc(0, 1, 3'd3, 32'd0);
    cyc(1, 0, 3'd3, 32'd0);
    #1 chk("commit_cnt_ffff", 64'(avs_readdata), 64'hFFFF);
    cyc(0, 1, 3'd3, 32'd0);
    cyc(1, 0, 3'd3, 32'd0);
    #1 chk("commit_cnt_wrap", 64'(avs_readdata), 64'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
